// File: rtl/add26_seq.sv
// add26_seq: 26-bit adder that reuses one 13-bit ripple adder over two passes
module Full_adder_13bits (
    input  logic [12:0] a,
    input  logic [12:0] b,
    input  logic        c_in,
    output logic [13:0] sum
);
    logic [13:0] c;
    assign c[0] = c_in;
    genvar i;
    generate
        for (i = 0; i < 13; i++) begin : g_fa
            assign sum[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate
    assign sum[13] = c[13];
endmodule

module add26_seq #(
    parameter int HALF_W = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    input  logic                c_in,
    output logic                busy,
    output logic                done,
    output logic [2*HALF_W:0]   sum
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t              state;
    logic [2*HALF_W-1:0] a_r, b_r;
    logic                cin_r, carry_r;
    logic [HALF_W-1:0]   add_a, add_b;
    logic                add_ci;
    logic [HALF_W:0]     add_s;
    logic                hi;
    assign hi     = state == HI;
    assign add_a  = hi ? a_r[2*HALF_W-1:HALF_W] : a_r[HALF_W-1:0];
    assign add_b  = hi ? b_r[2*HALF_W-1:HALF_W] : b_r[HALF_W-1:0];
    assign add_ci = hi ? carry_r : cin_r;
    assign busy   = state == LO || state == HI;
    assign done   = state == DONE;
    Full_adder_13bits u_add (
        .a    (add_a),
        .b    (add_b),
        .c_in (add_ci),
        .sum  (add_s)
    );
    // sequencer: capture operands, low pass, high pass, present result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            cin_r   <= 1'b0;
            carry_r <= 1'b0;
            sum     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        cin_r <= c_in;
                        state <= LO;
                    end else begin
                        state <= IDLE;
                    end
                end
                LO: begin
                    sum[HALF_W-1:0] <= add_s[HALF_W-1:0];
                    carry_r         <= add_s[HALF_W];
                    state           <= HI;
                end
                default: begin
                    sum[2*HALF_W:HALF_W] <= add_s;
                    state                <= DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add26_seq.sv
// tb_add26_seq: directed checks of the two-pass 26-bit adder
module tb_add26_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [25:0] a = '0, b = '0;
    logic        c_in = 1'b0;
    logic        busy, done;
    logic [26:0] sum;
    int          tests = 0, fails = 0;

    add26_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [25:0] oa, input logic [25:0] ob,
                          input logic oc, input logic [26:0] exp);
        int n;
        a = oa; b = ob; c_in = oc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 26'h2AAAAAA; b = 26'h1555555; c_in = ~oc;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd3);
        chk({tag, "_sum"}, {5'd0, sum}, {5'd0, exp});
        tick();
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dcnt;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {5'd0, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("half_carry", 26'h0001FFF, 26'h0000001, 1'b0, 27'h0002000);
        run_op("full_chain", 26'h3FFFFFF, 26'h0000001, 1'b0, 27'h4000000);
        run_op("max", 26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 27'h7FFFFFF);
        run_op("mixed", 26'h2345678, 26'h1234567, 1'b0, 27'h3579BDF);
        run_op("alt_cin", 26'h1555555, 26'h0AAAAAA, 1'b1, 27'h2000000);

        // start pulsed while in LO must be ignored
        a = 26'h5; b = 26'h3; c_in = 1'b0; start = 1'b1;
        tick();
        a = 26'h1111111; b = 26'h1111111; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_hi_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_sum", {5'd0, sum}, 32'h0000008);
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            dcnt += int'(done);
        end
        chk("ign_single", dcnt, 32'd0);

        // back-to-back with start held high
        a = 26'h10; b = 26'h20; c_in = 1'b0; start = 1'b1;
        tick();
        a = 26'h1000000; b = 26'h1000000;
        tick();
        chk("b2b_hi1", {31'd0, done}, 32'd0);
        tick();
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_sum1", {5'd0, sum}, 32'h0000030);
        tick();
        chk("b2b_lo2", {30'd0, busy, done}, 32'd2);
        tick();
        chk("b2b_hi2", {30'd0, busy, done}, 32'd2);
        tick();
        start = 1'b0;
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_sum2", {5'd0, sum}, 32'h2000000);
        tick();
        chk("b2b_end", {31'd0, done}, 32'd0);

        // reset while in HI aborts the operation
        a = 26'h0001000; b = 26'h0001000; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_hi_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_sum", {5'd0, sum}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            dcnt += int'(done) + int'(busy);
        end
        chk("mid_no_done", dcnt, 32'd0);
        chk("mid_sum_hold", {5'd0, sum}, 32'd0);

        run_op("after_rst", 26'h0001000, 26'h0001000, 1'b0, 27'h0002000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
